writeback_regfile: RTL and testbench



---
 rtl/y86_pkg.sv | 34 +++
 rtl/regfile_2w.sv | 37 +++
 rtl/writeback_regfile.sv | 128 ++++++++++++
 tb/tb_writeback_regfile.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, register ids, icodes, write-back state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package y86_pkg;

  localparam int NUM_REGS = 15;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    WB_RUN,
    WB_HALTED
  } wb_state_t;

endpackage

// File: rtl/regfile_2w.sv
// 15x64 register array with two write ports; port M overrides port E on the same register.
// Latency: writes land on the clock edge, regs shows them the following cycle.
// Backpressure: none; enables are qualified by the caller.
module regfile_2w
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_e,
  input  logic [3:0]                   dst_e,
  input  logic [63:0]                  val_e,
  input  logic                         we_m,
  input  logic [3:0]                   dst_m,
  input  logic [63:0]                  val_m,
  output logic [NUM_REGS-1:0][63:0]    regs
);

  // Reset loads %rsp with its initial value; otherwise M has priority over E per register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (4'(i) == REG_RSP) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_m && dst_m == 4'(i)) begin
          regs[i] <= val_m;
        end else if (we_e && dst_e == 4'(i)) begin
          regs[i] <= val_e;
        end
      end
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file; latches final status and counts retirements.
// Latency: register writes visible next cycle (same cycle when WB_BYPASS_EN is defined).
// Backpressure: W_stall holds the W instruction; it commits exactly once on the first unstalled edge.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  input  logic             W_stall,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  output logic [63:0]      value0,
  output logic [63:0]      value1,
  output logic [63:0]      value2,
  output logic [63:0]      value3,
  output logic [63:0]      value4,
  output logic [63:0]      value5,
  output logic [63:0]      value6,
  output logic [63:0]      value7,
  output logic [63:0]      value8,
  output logic [63:0]      value9,
  output logic [63:0]      value10,
  output logic [63:0]      value11,
  output logic [63:0]      value12,
  output logic [63:0]      value13,
  output logic [63:0]      value14,
  output logic [3:0]       wb_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  wb_state_t                   state;
  logic                        commit;
  logic                        we_e;
  logic                        we_m;
  logic [NUM_REGS-1:0][63:0]   regs;
  logic [NUM_REGS-1:0][63:0]   view;

  // A faulting instruction (stat != AOK) never writes, even with valid destinations.
  assign commit = (state == WB_RUN) && !W_stall && (W_stat == STAT_AOK);
  assign we_e   = commit && (W_dstE != REG_NONE);
  assign we_m   = commit && (W_dstM != REG_NONE);

  regfile_2w #(
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we_e  (we_e),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .we_m  (we_m),
    .dst_m (W_dstM),
    .val_m (W_valM),
    .regs  (regs)
  );

  // Run/halt state machine with the status latch and saturating retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WB_RUN;
      wb_stat <= STAT_AOK;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        WB_RUN: begin
          if (!W_stall) begin
            if (W_stat == STAT_AOK) begin
              if (W_icode != I_NOP && retired != {CNT_W{1'b1}}) begin
                retired <= retired + CNT_W'(1);
              end
            end else begin
              wb_stat <= W_stat;
              halted  <= 1'b1;
              state   <= WB_HALTED;
            end
          end
        end
        WB_HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= WB_HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Read view: plain register contents, or write-through of this cycle's commit when bypass is built in.
  always_comb begin
    view = regs;
`ifdef WB_BYPASS_EN
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && W_dstM == 4'(i)) begin
        view[i] = W_valM;
      end else if (commit && W_dstE == 4'(i)) begin
        view[i] = W_valE;
      end
    end
`endif
  end

  assign value0  = view[0];
  assign value1  = view[1];
  assign value2  = view[2];
  assign value3  = view[3];
  assign value4  = view[4];
  assign value5  = view[5];
  assign value6  = view[6];
  assign value7  = view[7];
  assign value8  = view[8];
  assign value9  = view[9];
  assign value10 = view[10];
  assign value11 = view[11];
  assign value12 = view[12];
  assign value13 = view[13];
  assign value14 = view[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: exercises W_stall randomly and in directed holds.
module tb_writeback_regfile;
  import y86_pkg::*;

  localparam logic [63:0] RSP_INIT = 64'h200;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       W_icode, W_stat, W_dstE, W_dstM;
  logic             W_stall;
  logic [63:0]      W_valE, W_valM;
  logic [63:0]      val [15];
  logic [3:0]       wb_stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  writeback_regfile #(.RSP_INIT(RSP_INIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .W_icode(W_icode), .W_stat(W_stat), .W_stall(W_stall),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .value0(val[0]), .value1(val[1]), .value2(val[2]), .value3(val[3]), .value4(val[4]),
    .value5(val[5]), .value6(val[6]), .value7(val[7]), .value8(val[8]), .value9(val[9]),
    .value10(val[10]), .value11(val[11]), .value12(val[12]), .value13(val[13]), .value14(val[14]),
    .wb_stat(wb_stat), .halted(halted), .retired(retired)
  );

  // Reference model: architectural state only.
  logic [63:0] m_reg [15];
  logic [3:0]  m_stat;
  bit          m_halted;
  int          m_ret;
  bit          m_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_view(input int n);
    logic [63:0] v;
    v = m_reg[n];
    if (BYPASS && !m_halted && !W_stall && W_stat == STAT_AOK) begin
      if (W_dstM == 4'(n)) v = W_valM;
      else if (W_dstE == 4'(n)) v = W_valE;
    end
    return v;
  endfunction

  task automatic check_all();
    if (!m_valid) return;
    if (!(BYPASS && rst)) begin
      for (int n = 0; n < 15; n++) check($sformatf("value%0d", n), val[n], exp_view(n));
    end
    check("wb_stat", 64'(wb_stat), 64'(m_stat));
    check("halted", 64'(halted), 64'(m_halted));
    check("retired", 64'(retired), 64'(m_ret));
  endtask

  // Apply the architectural effect of one clock edge with the currently driven inputs.
  task automatic model_edge();
    if (rst) begin
      for (int n = 0; n < 15; n++) m_reg[n] = (n == 4) ? RSP_INIT : 64'h0;
      m_stat = STAT_AOK;
      m_halted = 1'b0;
      m_ret = 0;
      m_valid = 1'b1;
    end else if (!m_halted && !W_stall) begin
      if (W_stat == STAT_AOK) begin
        if (W_dstE != 4'hF) m_reg[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_reg[W_dstM] = W_valM;
        if (W_icode != I_NOP && m_ret < CNT_MAX) m_ret++;
      end else begin
        m_stat = W_stat;
        m_halted = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic stall, input logic [3:0] icode, input logic [3:0] stat,
                     input logic [3:0] dste, input logic [63:0] vale,
                     input logic [3:0] dstm, input logic [63:0] valm);
    rst = r; W_stall = stall; W_icode = icode; W_stat = stat;
    W_dstE = dste; W_valE = vale; W_dstM = dstm; W_valM = valm;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Quiesce inputs without advancing the clock so registered state can be read directly.
  task automatic settle();
    rst = 1'b0; W_stall = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; W_stall = 1'b1; W_icode = I_NOP; W_stat = STAT_AOK;
    W_dstE = REG_NONE; W_valE = '0; W_dstM = REG_NONE; W_valM = '0;
    @(negedge clk);

    // Reset
    cyc(1, 1, I_NOP, STAT_AOK, REG_NONE, 0, REG_NONE, 0);
    settle();
    check("rst_value4", val[4], 64'h200);
    check("rst_value0", val[0], 64'h0);
    check("rst_value14", val[14], 64'h0);
    check("rst_stat", 64'(wb_stat), 64'd1);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);

    // irmovq into reg 2
    cyc(0, 0, I_IRMOVQ, STAT_AOK, 4'd2, 64'h55, REG_NONE, 0);
    settle();
    check("irmovq_value2", val[2], 64'h55);
    check("irmovq_retired", 64'(retired), 64'd1);

    // popq %rsp: M wins
    cyc(0, 0, I_POPQ, STAT_AOK, 4'd4, 64'h108, 4'd4, 64'hABCD);
    settle();
    check("popq_value4", val[4], 64'hABCD);
    check("popq_retired", 64'(retired), 64'd2);

    // Stalled write commits once
    for (int k = 0; k < 3; k++) cyc(0, 1, I_IRMOVQ, STAT_AOK, 4'd3, 64'h7, REG_NONE, 0);
    settle();
    check("stall_hold_value3", val[3], 64'h0);
    cyc(0, 0, I_IRMOVQ, STAT_AOK, 4'd3, 64'h7, REG_NONE, 0);
    settle();
    check("stall_value3", val[3], 64'h7);
    check("stall_retired", 64'(retired), 64'd3);

    // Bubbles
    for (int k = 0; k < 10; k++) cyc(0, 0, I_NOP, STAT_AOK, REG_NONE, 64'hDEAD, REG_NONE, 64'hBEEF);
    settle();
    check("bubble_retired", 64'(retired), 64'd3);

    // ADR halts and writes nothing
    cyc(0, 0, I_MRMOVQ, STAT_ADR, 4'd1, 64'h99, REG_NONE, 0);
    settle();
    check("adr_value1", val[1], 64'h0);
    check("adr_stat", 64'(wb_stat), 64'd3);
    check("adr_halted", 64'(halted), 64'd1);
    cyc(0, 0, I_IRMOVQ, STAT_AOK, 4'd1, 64'h123, REG_NONE, 0);
    settle();
    check("halted_value1", val[1], 64'h0);
    check("halted_retired", 64'(retired), 64'd3);
    cyc(1, 1, I_NOP, STAT_AOK, REG_NONE, 0, REG_NONE, 0);
    settle();
    check("rerun_halted", 64'(halted), 64'd0);
    check("rerun_stat", 64'(wb_stat), 64'd1);

    // Reset overrides a same-cycle commit
    cyc(0, 0, I_IRMOVQ, STAT_AOK, 4'd5, 64'h11, REG_NONE, 0);
    cyc(1, 0, I_IRMOVQ, STAT_AOK, 4'd5, 64'h77, REG_NONE, 0);
    settle();
    check("rst_override_value5", val[5], 64'h0);
    check("rst_override_retired", 64'(retired), 64'd0);

    // Saturation of the retire counter
    for (int k = 0; k < 20; k++) cyc(0, 0, I_IRMOVQ, STAT_AOK, REG_NONE, 0, REG_NONE, 0);
    settle();
    check("sat_retired", 64'(retired), 64'hF);

    // Random traffic
    cyc(1, 1, I_NOP, STAT_AOK, REG_NONE, 0, REG_NONE, 0);
    for (int k = 0; k < 400; k++) begin
      logic       r, s;
      logic [3:0] st;
      r  = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(2, 4)) : STAT_AOK;
      cyc(r, s, 4'($urandom), st, 4'($urandom), {$urandom, $urandom},
          4'($urandom), {$urandom, $urandom});
    end
    settle();
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
